// File: rtl/decode_queue_pkg.sv
// rtl/decode_queue_pkg.sv - RV32I opcode constants, format enum and format classifier
package decode_queue_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  // Every listed opcode ends in 2'b11, so an unlisted opcode also covers the
  // compressed-encoding case.
  function automatic fmt_e fmt_of(input logic [6:0] opcode);
    fmt_e fmt;
    case (opcode)
      OPC_OP:                                    fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
      OPC_STORE:                                 fmt = FMT_S;
      OPC_BRANCH:                                fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                        fmt = FMT_U;
      OPC_JAL:                                   fmt = FMT_J;
      default:                                   fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// rtl/decode_queue_if.sv - fetch/consumer handshake and decoded-field bundle for decode_queue
interface decode_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] pc_i;
  logic [31:0]     insn_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] pc_o;
  logic [31:0]     insn_o;
  logic [6:0]      opcode_o;
  logic [4:0]      rd_o;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [2:0]      funct3_o;
  logic [6:0]      funct7_o;
  logic [4:0]      shamt_o;
  logic [XLEN-1:0] imm_o;
  logic            illegal_o;
  logic [CW-1:0]   count_o;

  modport master (
    output flush_i, in_valid_i, pc_i, insn_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
           funct3_o, funct7_o, shamt_o, imm_o, illegal_o, count_o
  );

  modport slave (
    input  flush_i, in_valid_i, pc_i, insn_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o,
           funct3_o, funct7_o, shamt_o, imm_o, illegal_o, count_o
  );

endinterface

// File: rtl/decode_queue_imm_gen.sv
// rtl/decode_queue_imm_gen.sv - RV32I immediate extraction, sign-extended, zero for R/unknown formats
module imm_gen
  import decode_queue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     insn,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic unused_opcode_bits;
  assign unused_opcode_bits = ^insn[6:0];

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{insn[31]}}, insn[31:20]};
      FMT_S: imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      FMT_B: imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      FMT_U: imm = {insn[31:12], 12'b0};
      FMT_J: imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - fetch-to-decode instruction FIFO with combinational RV32I field decode of the head
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  decode_queue_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     insn_mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;

  logic            in_ready;
  logic            out_valid;
  logic            push;
  logic            pop;

  assign in_ready  = count < CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = bus.in_valid_i && in_ready && !bus.flush_i;
  assign pop       = out_valid && bus.out_ready_i && !bus.flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (bus.flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy gating below hides stale contents.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wptr]   <= bus.pc_i;
      insn_mem[wptr] <= bus.insn_i;
    end
  end

  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_insn;
  fmt_e            fmt;
  logic [XLEN-1:0] imm;

  assign head_pc   = out_valid ? pc_mem[rptr]   : '0;
  assign head_insn = out_valid ? insn_mem[rptr] : '0;
  assign fmt       = fmt_of(head_insn[6:0]);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .insn (head_insn),
    .fmt  (fmt),
    .imm  (imm)
  );

  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] shamt;

  // An empty queue decodes as opcode 0 (FMT_BAD), so every field falls to zero.
  always_comb begin
    rd     = '0;
    rs1    = '0;
    rs2    = '0;
    funct3 = '0;
    funct7 = '0;
    shamt  = '0;
    case (fmt)
      FMT_R: begin
        rd     = head_insn[11:7];
        rs1    = head_insn[19:15];
        rs2    = head_insn[24:20];
        funct3 = head_insn[14:12];
        funct7 = head_insn[31:25];
      end
      FMT_I: begin
        rd     = head_insn[11:7];
        rs1    = head_insn[19:15];
        funct3 = head_insn[14:12];
      end
      FMT_S, FMT_B: begin
        rs1    = head_insn[19:15];
        rs2    = head_insn[24:20];
        funct3 = head_insn[14:12];
      end
      FMT_U, FMT_J: begin
        rd     = head_insn[11:7];
      end
      default: begin
        rd     = '0;
      end
    endcase
    if (head_insn[6:0] == OPC_OP_IMM &&
        (head_insn[14:12] == 3'b001 || head_insn[14:12] == 3'b101))
      shamt = head_insn[24:20];
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.count_o     = count;
  assign bus.pc_o        = head_pc;
  assign bus.insn_o      = head_insn;
  assign bus.opcode_o    = head_insn[6:0];
  assign bus.rd_o        = rd;
  assign bus.rs1_o       = rs1;
  assign bus.rs2_o       = rs2;
  assign bus.funct3_o    = funct3;
  assign bus.funct7_o    = funct7;
  assign bus.shamt_o     = shamt;
  assign bus.imm_o       = imm;
  assign bus.illegal_o   = out_valid && (fmt == FMT_BAD);

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - directed self-checking bench for decode_queue
module tb_decode_queue;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  decode_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

  decode_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] insn);
    bus.pc_i       = pc;
    bus.insn_i     = insn;
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic pop1();
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.pc_i       = '0;
    bus.insn_i     = '0;
    #1 rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_pc", bus.pc_o, 32'd0);
    chk("rst_illegal", 32'(bus.illegal_o), 32'd0);

    @(negedge clk);
    rst = 1'b1;

    // ADD x3,x4,x5 pushed on the first edge after reset release
    push(32'h0100_0000, 32'h005201B3);
    chk("add_valid", 32'(bus.out_valid_o), 32'd1);
    chk("add_pc", bus.pc_o, 32'h0100_0000);
    chk("add_opcode", 32'(bus.opcode_o), 32'h33);
    chk("add_rd", 32'(bus.rd_o), 32'd3);
    chk("add_rs1", 32'(bus.rs1_o), 32'd4);
    chk("add_rs2", 32'(bus.rs2_o), 32'd5);
    chk("add_funct3", 32'(bus.funct3_o), 32'd0);
    chk("add_funct7", 32'(bus.funct7_o), 32'd0);
    chk("add_imm", bus.imm_o, 32'd0);
    chk("add_illegal", 32'(bus.illegal_o), 32'd0);
    @(negedge clk);
    chk("add_hold_pc", bus.pc_o, 32'h0100_0000);
    chk("add_hold_insn", bus.insn_o, 32'h005201B3);
    pop1();
    chk("add_pop_count", 32'(bus.count_o), 32'd0);

    // SW x7,8(x9)
    push(32'h0100_0004, 32'h0074A423);
    chk("sw_rd", 32'(bus.rd_o), 32'd0);
    chk("sw_rs1", 32'(bus.rs1_o), 32'd9);
    chk("sw_rs2", 32'(bus.rs2_o), 32'd7);
    chk("sw_funct3", 32'(bus.funct3_o), 32'd2);
    chk("sw_imm", bus.imm_o, 32'h0000_0008);
    pop1();

    // BEQ x1,x0,-4
    push(32'h0100_0008, 32'hFE008EE3);
    chk("beq_imm", bus.imm_o, 32'hFFFF_FFFC);
    chk("beq_rd", 32'(bus.rd_o), 32'd0);
    chk("beq_rs1", 32'(bus.rs1_o), 32'd1);
    pop1();

    // SLLI x1,x2,5
    push(32'h0100_000C, 32'h00511093);
    chk("slli_shamt", 32'(bus.shamt_o), 32'd5);
    chk("slli_imm", bus.imm_o, 32'd5);
    chk("slli_rs2", 32'(bus.rs2_o), 32'd0);
    chk("slli_rd", 32'(bus.rd_o), 32'd1);
    pop1();

    // LUI x5,0x12345
    push(32'h0100_0010, 32'h123452B7);
    chk("lui_imm", bus.imm_o, 32'h1234_5000);
    chk("lui_rd", 32'(bus.rd_o), 32'd5);
    chk("lui_rs1", 32'(bus.rs1_o), 32'd0);
    chk("lui_funct3", 32'(bus.funct3_o), 32'd0);
    chk("lui_shamt", 32'(bus.shamt_o), 32'd0);
    pop1();
    chk("empty_count", 32'(bus.count_o), 32'd0);

    // Fill to DEPTH; write pointer starts at 1 so storage wraps
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(i) * 4, 32'h005201B3);
    chk("full_count", 32'(bus.count_o), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready_o), 32'd0);
    push(32'h110, 32'h005201B3);
    chk("full_drop_count", 32'(bus.count_o), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("full_order_pc", bus.pc_o, 32'h100 + 32'(i) * 4);
      pop1();
    end
    chk("drain_count", 32'(bus.count_o), 32'd0);
    chk("drain_valid", 32'(bus.out_valid_o), 32'd0);

    // Simultaneous push and pop at count 2
    push(32'h200, 32'h005201B3);
    push(32'h204, 32'h005201B3);
    chk("pp_pre_count", 32'(bus.count_o), 32'd2);
    chk("pp_pre_pc", bus.pc_o, 32'h200);
    bus.pc_i = 32'h208;
    bus.insn_i = 32'h005201B3;
    bus.in_valid_i = 1'b1;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    chk("pp_count", 32'(bus.count_o), 32'd2);
    chk("pp_pc1", bus.pc_o, 32'h204);
    pop1();
    chk("pp_pc2", bus.pc_o, 32'h208);
    pop1();
    chk("pp_empty", 32'(bus.count_o), 32'd0);

    // Flush at count 3 with a competing push
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(i) * 4, 32'h005201B3);
    chk("fl_pre_count", 32'(bus.count_o), 32'd3);
    bus.flush_i = 1'b1;
    bus.pc_i = 32'h30C;
    bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("fl_count", 32'(bus.count_o), 32'd0);
    chk("fl_valid", 32'(bus.out_valid_o), 32'd0);
    chk("fl_pc_zero", bus.pc_o, 32'd0);
    push(32'h400, 32'h005201B3);
    chk("fl_after_pc", bus.pc_o, 32'h400);
    chk("fl_after_count", 32'(bus.count_o), 32'd1);
    pop1();

    // Illegal encodings, then asynchronous reset mid-stream
    push(32'h500, 32'h0000_0000);
    chk("ill_zero", 32'(bus.illegal_o), 32'd1);
    chk("ill_imm", bus.imm_o, 32'd0);
    pop1();
    push(32'h504, 32'h005201B2);
    chk("ill_lowbits", 32'(bus.illegal_o), 32'd1);
    push(32'h508, 32'h005201B3);
    chk("ar_pre_count", 32'(bus.count_o), 32'd2);
    #3 rst = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.out_valid_o), 32'd0);
    chk("ar_count", 32'(bus.count_o), 32'd0);
    chk("ar_in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("ar_pc", bus.pc_o, 32'd0);
    chk("ar_insn", bus.insn_o, 32'd0);
    chk("ar_illegal", 32'(bus.illegal_o), 32'd0);
    chk("ar_opcode", 32'(bus.opcode_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    push(32'h600, 32'h005201B3);
    chk("ar_push_count", 32'(bus.count_o), 32'd1);
    chk("ar_push_pc", bus.pc_o, 32'h600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
